// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared address map, CTRL bit layout and debounce default for the MMIO stage
package mmio_pkg;

  localparam logic [31:0] ADDR_HEX   = 32'hF000_0000;
  localparam logic [31:0] ADDR_LEDR  = 32'hF000_0004;
  localparam logic [31:0] ADDR_KDATA = 32'hF000_0010;
  localparam logic [31:0] ADDR_SDATA = 32'hF000_0014;
  localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;
  localparam logic [31:0] ADDR_SCTRL = 32'hF000_0114;

  localparam int CTRL_READY = 0;
  localparam int CTRL_OVR   = 2;
  localparam int CTRL_IE    = 8;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 10000;

  // Pack status bits into the CTRL register layout; unused bits read 0.
  function automatic logic [31:0] ctrl_word(input logic ready, input logic ovr, input logic ie);
    logic [31:0] w;
    w = '0;
    w[CTRL_READY] = ready;
    w[CTRL_OVR]   = ovr;
    w[CTRL_IE]    = ie;
    return w;
  endfunction

endpackage

// File: rtl/io_status_reg.sv
// rtl/io_status_reg.sv - ready/overrun/IE status with set/clear arbitration (IE writable only with IO_INTR_EN)
module io_status_reg (
  input  logic clk,
  input  logic reset,
  input  logic evt,
  input  logic rd_clr,
  input  logic ctrl_wr,
  input  logic wr_ovr,
  input  logic wr_ie,
  output logic ready,
  output logic ovr,
  output logic ie
);

  // Events beat read-clears; overrun set beats a software write-0 clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      if (evt)
        ready <= 1'b1;
      else if (rd_clr)
        ready <= 1'b0;
      if (evt && ready && !rd_clr)
        ovr <= 1'b1;
      else if (ctrl_wr && !wr_ovr)
        ovr <= 1'b0;
    end
  end

`ifdef IO_INTR_EN
  // Interrupt enable is a plain R/W bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ie <= 1'b0;
    else if (ctrl_wr)
      ie <= wr_ie;
  end
`else
  logic unused_wr_ie;
  assign unused_wr_ie = wr_ie;
  assign ie = 1'b0;
`endif

endmodule

// File: rtl/sw_debouncer.sv
// rtl/sw_debouncer.sv - switch synchronizer, stability window counter and debounced data register
module sw_debouncer #(
  parameter int WIDTH  = 10,
  parameter int CYCLES = 10000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sdata,
  output logic             evt
);

  localparam int CW = $clog2(CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] cand;
  logic [CW-1:0]    cnt;

  // A new value is published only once the window has elapsed and it differs from sdata.
  assign evt = (meta == cand) && (cnt == CNT_MAX) && (cand != sdata);

  // Candidate restarts the window on any change; counter saturates at its maximum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta  <= '0;
      cand  <= '0;
      cnt   <= '0;
      sdata <= '0;
    end else begin
      meta <= sw_in;
      if (meta != cand) begin
        cand <= meta;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (evt)
        sdata <= cand;
    end
  end

endmodule

// File: rtl/mmio_controller.sv
// rtl/mmio_controller.sv - MMIO decode, HEX/LEDR registers, KEY/SW status; IO_INTR_EN enables irq
module mmio_controller
  import mmio_pkg::*;
#(
  parameter int DBITS           = 32,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [DBITS-1:0] wr_data,
  output logic [DBITS-1:0] rd_data,
  output logic             io_hit,
  input  logic [3:0]       key_in,
  input  logic [9:0]       sw_in,
  output logic [15:0]      hex_out,
  output logic [9:0]       ledr_out,
  output logic             irq
);

  logic [3:0] key_meta;
  logic [3:0] kdata;
  logic       k_evt;
  logic [9:0] sdata;
  logic       s_evt;
  logic       k_ready, k_ovr, k_ie;
  logic       s_ready, s_ovr, s_ie;

  logic unused_wr_hi;
  assign unused_wr_hi = ^wr_data[DBITS-1:16];

  // KEY pins are active-low; the second sync stage is the KDATA register itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_meta <= '0;
      kdata    <= '0;
    end else begin
      key_meta <= ~key_in;
      kdata    <= key_meta;
    end
  end

  assign k_evt = (key_meta != kdata);

  // Output registers take store data on a matching write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex_out  <= '0;
      ledr_out <= '0;
    end else begin
      if (wr_en && addr == ADDR_HEX)
        hex_out <= wr_data[15:0];
      if (wr_en && addr == ADDR_LEDR)
        ledr_out <= wr_data[9:0];
    end
  end

  sw_debouncer #(.WIDTH(10), .CYCLES(DEBOUNCE_CYCLES)) u_sw (
    .clk   (clk),
    .reset (reset),
    .sw_in (sw_in),
    .sdata (sdata),
    .evt   (s_evt)
  );

  io_status_reg u_kstat (
    .clk     (clk),
    .reset   (reset),
    .evt     (k_evt),
    .rd_clr  (rd_en && addr == ADDR_KDATA),
    .ctrl_wr (wr_en && addr == ADDR_KCTRL),
    .wr_ovr  (wr_data[CTRL_OVR]),
    .wr_ie   (wr_data[CTRL_IE]),
    .ready   (k_ready),
    .ovr     (k_ovr),
    .ie      (k_ie)
  );

  io_status_reg u_sstat (
    .clk     (clk),
    .reset   (reset),
    .evt     (s_evt),
    .rd_clr  (rd_en && addr == ADDR_SDATA),
    .ctrl_wr (wr_en && addr == ADDR_SCTRL),
    .wr_ovr  (wr_data[CTRL_OVR]),
    .wr_ie   (wr_data[CTRL_IE]),
    .ready   (s_ready),
    .ovr     (s_ovr),
    .ie      (s_ie)
  );

  // Zero-latency read mux; unmapped addresses read 0 and do not hit.
  always_comb begin
    rd_data = '0;
    io_hit  = 1'b1;
    case (addr)
      ADDR_HEX:   rd_data = DBITS'(hex_out);
      ADDR_LEDR:  rd_data = DBITS'(ledr_out);
      ADDR_KDATA: rd_data = DBITS'(kdata);
      ADDR_SDATA: rd_data = DBITS'(sdata);
      ADDR_KCTRL: rd_data = DBITS'(ctrl_word(k_ready, k_ovr, k_ie));
      ADDR_SCTRL: rd_data = DBITS'(ctrl_word(s_ready, s_ovr, s_ie));
      default:    io_hit  = 1'b0;
    endcase
  end

`ifdef IO_INTR_EN
  // Interrupt is registered, so it follows ready by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      irq <= 1'b0;
    else
      irq <= (k_ready & k_ie) | (s_ready & s_ie);
  end
`else
  assign irq = 1'b0;
`endif

endmodule
